ula_issue_ctrl: RTL

Sequencer and register file that sits in front of the combinational `ULA`. It accepts 16-bit instruction words over a valid/ready handshake and reads operands from an internal 16x16 register file. It drives `CodeULA`/`OpA`/`OpB` from registers, samples `Res`/`FlagReg` back, and retires the instruction as a register writeback, a flags update, or a BEZ branch redirect.

---
 rtl/ula_issue_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/ula_issue_ctrl.sv
// ula_issue_ctrl: issue sequencer and 16x16 register file in front of the
// combinational ULA. One instruction in flight: IDLE -> EXEC -> RETIRE.
module ula_issue_ctrl #(
  parameter int unsigned NREG     = 16,
  parameter logic [3:0]  NOP_CODE = 4'b0111
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        InstrValid,
  input  logic [15:0] Instr,
  output logic        InstrReady,
  output logic [3:0]  CodeULA,
  output logic [15:0] OpA,
  output logic [15:0] OpB,
  input  logic [15:0] Res,
  input  logic [2:0]  FlagReg,
  output logic [2:0]  Flags,
  output logic        WbValid,
  output logic [3:0]  WbAddr,
  output logic [15:0] WbData,
  output logic        BranchTaken,
  output logic [15:0] BranchTarget,
  output logic        IllegalOp,
  input  logic [3:0]  DbgAddr,
  output logic [15:0] DbgData
);

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXEC   = 2'd1;
  localparam logic [1:0] S_RETIRE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_BEZ = 4'b0110;
  localparam logic [3:0] OP_NOP = 4'b0111;
  localparam logic [3:0] OP_LDI = 4'b1000;

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic          w_accept;
  logic          w_exec;

  logic [DW-1:0] r_rf [NREG];

  // Latched decode of the in-flight instruction
  logic [AW-1:0] r_rd;
  logic          r_wr;
  logic          r_bez;
  logic          r_ill;

  logic [3:0]    w_op;
  logic [AW-1:0] w_rs;
  logic [AW-1:0] w_rt;
  logic [DW-1:0] w_rs_val;
  logic [DW-1:0] w_rt_val;
  logic [3:0]    w_code;
  logic [DW-1:0] w_opa;
  logic [DW-1:0] w_opb;
  logic          w_wr;
  logic          w_bez;
  logic          w_ill;

  assign w_op = Instr[15:12];
  assign w_rs = Instr[7:4];
  assign w_rt = Instr[3:0];

  // R0 reads as zero regardless of array contents
  assign w_rs_val = (w_rs == '0) ? '0 : r_rf[w_rs];
  assign w_rt_val = (w_rt == '0) ? '0 : r_rf[w_rt];
  assign DbgData  = (DbgAddr == '0) ? '0 : r_rf[DbgAddr];

  // State register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic and the accept/execute strobes
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_exec   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (InstrValid) begin
          w_accept = 1'b1;
          w_next   = S_EXEC;
        end
      end
      S_EXEC: begin
        w_exec = 1'b1;
        w_next = S_RETIRE;
      end
      S_RETIRE: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Decode of the incoming word into ULA controls and retire kind
  always_comb begin
    w_code = OP_NOP;
    w_opa  = '0;
    w_opb  = '0;
    w_wr   = 1'b0;
    w_bez  = 1'b0;
    w_ill  = 1'b0;
    if (w_op <= OP_XOR) begin
      w_code = w_op;
      w_opa  = w_rs_val;
      w_opb  = w_rt_val;
      w_wr   = 1'b1;
    end else if (w_op == OP_BEZ) begin
      w_code = OP_BEZ;
      w_opa  = w_rs_val;
      w_opb  = w_rt_val;
      w_bez  = 1'b1;
    end else if (w_op == OP_NOP) begin
      w_code = OP_NOP;
    end else if (w_op == OP_LDI) begin
      w_code = OP_ADD;
      w_opb  = {8'h00, Instr[7:0]};
      w_wr   = 1'b1;
    end else begin
      w_code = OP_NOP;
      w_ill  = 1'b1;
    end
  end

  // ULA drive, retire pulses and architectural outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      InstrReady   <= 1'b1;
      CodeULA      <= NOP_CODE;
      OpA          <= '0;
      OpB          <= '0;
      Flags        <= '0;
      WbValid      <= 1'b0;
      WbAddr       <= '0;
      WbData       <= '0;
      BranchTaken  <= 1'b0;
      BranchTarget <= '0;
      IllegalOp    <= 1'b0;
      r_rd         <= '0;
      r_wr         <= 1'b0;
      r_bez        <= 1'b0;
      r_ill        <= 1'b0;
    end else begin
      InstrReady  <= (w_next == S_IDLE);
      WbValid     <= 1'b0;
      BranchTaken <= 1'b0;
      IllegalOp   <= 1'b0;
      if (w_accept) begin
        CodeULA <= w_code;
        OpA     <= w_opa;
        OpB     <= w_opb;
        r_rd    <= Instr[11:8];
        r_wr    <= w_wr;
        r_bez   <= w_bez;
        r_ill   <= w_ill;
      end else begin
        CodeULA <= NOP_CODE;
        OpA     <= '0;
        OpB     <= '0;
      end
      if (w_exec) begin
        if (r_wr) begin
          Flags <= FlagReg;
          if (r_rd != '0) begin
            WbValid <= 1'b1;
            WbAddr  <= r_rd;
            WbData  <= Res;
          end
        end
        if (r_bez) begin
          BranchTaken  <= FlagReg[2];
          BranchTarget <= Res;
        end
        if (r_ill) IllegalOp <= 1'b1;
      end
    end
  end

  // Register file write port; R0 is never written
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < int'(NREG); i++) r_rf[i] <= '0;
    end else if (w_exec && r_wr && (r_rd != '0)) begin
      r_rf[r_rd] <= Res;
    end
  end

endmodule
